// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states and fetch constants.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a flush loads a NOP bubble and takes precedence over load.
module if_id_reg
   import mips_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic                   flush_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic [PC_WIDTH-1:0]    pc4_i,
   input  logic                   valid_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [PC_WIDTH-1:0]    pc4_o,
   output logic                   valid_o
);

   logic [INSTR_WIDTH-1:0] instr_q;
   logic [PC_WIDTH-1:0]    pc4_q;
   logic                   valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= INSTR_WIDTH'(NOP);
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         instr_q <= INSTR_WIDTH'(NOP);
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc4_q   <= pc4_i;
         valid_q <= valid_i;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, one-entry hold buffer and IF/ID register.
module if_stage
   import mips_pkg::*;
#(
   parameter int unsigned         PC_WIDTH    = 32,
   parameter int unsigned         INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pc_write,
   input  logic                   if_id_write,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ready,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] if_id_instr,
   output logic [PC_WIDTH-1:0]    if_id_pc4,
   output logic                   if_id_valid,
   output logic                   fetch_busy
);

   fetch_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] buf_q, buf_d;
   logic                   req_q, req_d;
   logic                   load, flush;
   logic [INSTR_WIDTH-1:0] ld_instr;
   logic                   adv, accept;
   logic [PC_WIDTH-1:0]    pc_plus4, tgt_aligned;

   assign adv         = pc_write & if_id_write;
   assign accept      = req_q & imem_ready;
   assign pc_plus4    = pc_q + PC_WIDTH'(PC_INC);
   assign tgt_aligned = branch_target & ~PC_WIDTH'(3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // A redirect with the old response still pending must swallow that response.
   always_comb begin
      state_d = state_q;
      if (branch_taken) begin
         state_d = (req_q && !imem_ready) ? DISCARD : FETCH;
      end else begin
         unique case (state_q)
            FETCH:   if (accept && !adv) state_d = HOLD;
            HOLD:    if (adv)            state_d = FETCH;
            DISCARD: if (imem_ready)     state_d = FETCH;
            default:                     state_d = FETCH;
         endcase
      end
   end

   always_comb begin
      pc_d     = pc_q;
      buf_d    = buf_q;
      load     = 1'b0;
      flush    = 1'b0;
      ld_instr = imem_rdata;
      req_d    = (state_d != HOLD);
      if (branch_taken) begin
         pc_d  = tgt_aligned;
         buf_d = '0;
         flush = 1'b1;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (accept && adv) begin
                  load = 1'b1;
                  pc_d = pc_plus4;
               end else if (accept) begin
                  buf_d = imem_rdata;
               end else if (if_id_write) begin
                  flush = 1'b1;
               end
            end
            HOLD: begin
               if (adv) begin
                  load     = 1'b1;
                  ld_instr = buf_q;
                  pc_d     = pc_plus4;
               end
            end
            DISCARD: if (if_id_write) flush = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         buf_q <= '0;
         req_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         buf_q <= buf_d;
         req_q <= req_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign fetch_busy = (state_q == DISCARD) | ((state_q == FETCH) & ~imem_ready);

   if_id_reg #(
      .PC_WIDTH   (PC_WIDTH),
      .INSTR_WIDTH(INSTR_WIDTH)
   ) u_if_id_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .flush_i(flush),
      .instr_i(ld_instr),
      .pc4_i  (pc_plus4),
      .valid_i(1'b1),
      .instr_o(if_id_instr),
      .pc4_o  (if_id_pc4),
      .valid_o(if_id_valid)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_write, if_id_write, branch_taken, imem_ready;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, if_id_valid, fetch_busy;
   logic [31:0] imem_addr, if_id_instr, if_id_pc4;

   int tests_run = 0;
   int tests_failed = 0;

   // Behavioural model: architectural PC, IF/ID contents, and whether we hold a word or drain a stale one
   logic [31:0] m_pc, m_buf, m_instr, m_pc4;
   logic        m_valid, m_req, m_hold, m_disc;

   always #5 clk = ~clk;

   if_stage #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .if_id_instr  (if_id_instr),
      .if_id_pc4    (if_id_pc4),
      .if_id_valid  (if_id_valid),
      .fetch_busy   (fetch_busy)
   );

   task automatic model_reset();
      m_pc = RST_PC; m_buf = 0; m_instr = 0; m_pc4 = 0;
      m_valid = 0; m_req = 0; m_hold = 0; m_disc = 0;
   endtask

   task automatic drive(input logic pw, input logic iw, input logic br,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
      pc_write = pw; if_id_write = iw; branch_taken = br;
      branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
      #1;
   endtask

   // Advance the model by one clock from the current inputs, then let the DUT take the edge.
   task automatic clock_edge();
      logic acc, adv_l;
      acc   = m_req & imem_ready;
      adv_l = pc_write & if_id_write;
      if (branch_taken) begin
         m_pc = branch_target & 32'hFFFF_FFFC;
         m_instr = 0; m_pc4 = 0; m_valid = 0;
         m_buf = 0; m_hold = 0;
         m_disc = m_req & ~imem_ready;
      end else if (m_hold) begin
         if (adv_l) begin
            m_instr = m_buf; m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_hold = 0;
         end
      end else if (m_disc) begin
         if (imem_ready) m_disc = 0;
         if (if_id_write) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      end else if (acc && adv_l) begin
         m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1;
         m_pc = m_pc + 4;
      end else if (acc) begin
         m_buf = imem_rdata; m_hold = 1;
      end else if (if_id_write) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end
      m_req = ~m_hold;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1, 1, 0, 32'h0, 1, 32'h1234_5678);
      #2;
      tests_run++; if (if_id_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h0); end
      tests_run++; if (if_id_pc4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pc4: got %h want %h", if_id_pc4, 32'h0); end
      tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
      tests_run++; if (imem_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd;
      drive(1, 1, 0, 32'h0, 1, $urandom);
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL zw_first_req: got %b want 0", imem_req); end
      clock_edge();
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL zw_req_rise: got %b want 1", imem_req); end
      tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_valid_c1: got %b want 0", if_id_valid); end
      for (int i = 0; i < 2; i++) begin
         rd = $urandom;
         drive(1, 1, 0, 32'h0, 1, rd);
         tests_run++; if (imem_addr !== 32'(4 * i)) begin tests_failed++; $display("FAIL zw_addr%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
         tests_run++; if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL zw_busy%0d: got %b want 0", i, fetch_busy); end
         clock_edge();
         tests_run++; if (if_id_pc4 !== 32'(4 * (i + 1))) begin tests_failed++; $display("FAIL zw_pc4_%0d: got %h want %h", i, if_id_pc4, 32'(4 * (i + 1))); end
         tests_run++; if (if_id_instr !== rd) begin tests_failed++; $display("FAIL zw_instr%0d: got %h want %h", i, if_id_instr, rd); end
         tests_run++; if (if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL zw_valid%0d: got %b want 1", i, if_id_valid); end
      end
   endtask

   task automatic test_load_use_stall();
      drive(0, 0, 0, 32'h0, 1, 32'h8C22_0000);
      tests_run++; if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL stall_addr: got %h want %h", imem_addr, 32'h8); end
      clock_edge();
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req: got %b want 0", imem_req); end
      tests_run++; if (if_id_pc4 !== 32'h8) begin tests_failed++; $display("FAIL stall_pc4_held: got %h want %h", if_id_pc4, 32'h8); end
      tests_run++; if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL stall_pc_held: got %h want %h", imem_addr, 32'h8); end
      drive(1, 1, 0, 32'h0, 0, $urandom);
      tests_run++; if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL hold_busy: got %b want 0", fetch_busy); end
      clock_edge();
      tests_run++; if (if_id_instr !== 32'h8C22_0000) begin tests_failed++; $display("FAIL hold_instr: got %h want %h", if_id_instr, 32'h8C22_0000); end
      tests_run++; if (if_id_pc4 !== 32'hC) begin tests_failed++; $display("FAIL hold_pc4: got %h want %h", if_id_pc4, 32'hC); end
      tests_run++; if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL hold_pc: got %h want %h", imem_addr, 32'hC); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL hold_req_back: got %b want 1", imem_req); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      drive(1, 1, 0, 32'h0, 1, $urandom);
      clock_edge();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 32'h0, 0, $urandom);
         tests_run++; if (fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL ws_busy%0d: got %b want 1", i, fetch_busy); end
         tests_run++; if (imem_addr !== 32'h10) begin tests_failed++; $display("FAIL ws_addr%0d: got %h want %h", i, imem_addr, 32'h10); end
         clock_edge();
         tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin tests_failed++; $display("FAIL ws_bubble%0d: got valid=%b instr=%h want valid=0 instr=0", i, if_id_valid, if_id_instr); end
      end
      rd = $urandom;
      drive(1, 1, 0, 32'h0, 1, rd);
      tests_run++; if (fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL ws_busy_ready: got %b want 0", fetch_busy); end
      clock_edge();
      tests_run++; if (if_id_instr !== rd) begin tests_failed++; $display("FAIL ws_instr: got %h want %h", if_id_instr, rd); end
      tests_run++; if (if_id_pc4 !== 32'h14 || imem_addr !== 32'h14) begin tests_failed++; $display("FAIL ws_pc: got pc4=%h addr=%h want 14/14", if_id_pc4, imem_addr); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 32'h0, 1, $urandom);
         clock_edge();
      end
      tests_run++; if (imem_addr !== 32'h20) begin tests_failed++; $display("FAIL ws_reach20: got %h want %h", imem_addr, 32'h20); end
   endtask

   task automatic test_branch_outstanding();
      logic [31:0] rd;
      drive(1, 1, 0, 32'h0, 0, $urandom);
      clock_edge();
      drive(1, 1, 1, 32'h40, 0, $urandom);
      clock_edge();
      tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL br_out_addr: got %h want %h", imem_addr, 32'h40); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL br_out_req: got %b want 1", imem_req); end
      tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL br_out_bubble: got %b want 0", if_id_valid); end
      drive(1, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
      tests_run++; if (fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL discard_busy: got %b want 1", fetch_busy); end
      clock_edge();
      tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin tests_failed++; $display("FAIL discard_drop: got valid=%b instr=%h want valid=0 instr=0", if_id_valid, if_id_instr); end
      tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL discard_addr: got %h want %h", imem_addr, 32'h40); end
      rd = $urandom;
      drive(1, 1, 0, 32'h0, 1, rd);
      clock_edge();
      tests_run++; if (if_id_instr !== rd || if_id_pc4 !== 32'h44) begin tests_failed++; $display("FAIL br_target_fetch: got instr=%h pc4=%h want %h/44", if_id_instr, if_id_pc4, rd); end
   endtask

   task automatic test_branch_accept_stall();
      logic [31:0] rd;
      drive(0, 0, 1, 32'h101, 1, $urandom);
      clock_edge();
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL bas_no_hold: got req=%b want 1", imem_req); end
      tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin tests_failed++; $display("FAIL bas_bubble: got valid=%b instr=%h want 0/0", if_id_valid, if_id_instr); end
      tests_run++; if (imem_addr !== 32'h100) begin tests_failed++; $display("FAIL bas_addr_aligned: got %h want %h", imem_addr, 32'h100); end
      rd = $urandom;
      drive(1, 1, 0, 32'h0, 1, rd);
      clock_edge();
      tests_run++; if (if_id_instr !== rd || if_id_pc4 !== 32'h104) begin tests_failed++; $display("FAIL bas_next: got instr=%h pc4=%h want %h/104", if_id_instr, if_id_pc4, rd); end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] rd;
      drive(1, 1, 1, 32'hFFFF_FFFE, 1, $urandom);
      clock_edge();
      tests_run++; if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_target: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
      rd = $urandom;
      drive(1, 1, 0, 32'h0, 1, rd);
      clock_edge();
      tests_run++; if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4: got pc4=%h addr=%h want 0/0", if_id_pc4, imem_addr); end
      tests_run++; if (if_id_instr !== rd) begin tests_failed++; $display("FAIL wrap_instr: got %h want %h", if_id_instr, rd); end
   endtask

   task automatic test_reset_mid_hold();
      logic [31:0] rd;
      drive(0, 0, 0, 32'h0, 1, $urandom);
      clock_edge();
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rmh_in_hold: got req=%b want 0", imem_req); end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL rmh_ifid_clear: got %h %h %b want 0 0 0", if_id_instr, if_id_pc4, if_id_valid); end
      tests_run++; if (imem_addr !== RST_PC || imem_req !== 1'b0) begin tests_failed++; $display("FAIL rmh_pc: got addr=%h req=%b want %h/0", imem_addr, imem_req, RST_PC); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(1, 1, 0, 32'h0, 1, $urandom);
      clock_edge();
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin tests_failed++; $display("FAIL rmh_refetch: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
      rd = $urandom;
      drive(1, 1, 0, 32'h0, 1, rd);
      clock_edge();
      tests_run++; if (if_id_instr !== rd || if_id_pc4 !== RST_PC + 32'h4) begin tests_failed++; $display("FAIL rmh_first: got instr=%h pc4=%h want %h/%h", if_id_instr, if_id_pc4, rd, RST_PC + 32'h4); end
   endtask

   task automatic test_random();
      logic pw, iw, br, rdy;
      for (int n = 0; n < 400; n++) begin
         pw  = ($urandom_range(0, 3) != 0);
         iw  = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 7) == 0);
         rdy = m_req & ($urandom_range(0, 1) == 1);
         drive(pw, iw, br, $urandom, rdy, $urandom);
         tests_run++; if (imem_req !== m_req || imem_addr !== m_pc) begin tests_failed++; $display("FAIL rnd_req_addr@%0d: got req=%b addr=%h want %b/%h", n, imem_req, imem_addr, m_req, m_pc); end
         tests_run++; if (fetch_busy !== (m_disc | (~m_hold & ~m_disc & ~rdy))) begin tests_failed++; $display("FAIL rnd_busy@%0d: got %b want %b", n, fetch_busy, m_disc | (~m_hold & ~m_disc & ~rdy)); end
         clock_edge();
         tests_run++; if (if_id_instr !== m_instr || if_id_pc4 !== m_pc4 || if_id_valid !== m_valid) begin tests_failed++; $display("FAIL rnd_ifid@%0d: got %h %h %b want %h %h %b", n, if_id_instr, if_id_pc4, if_id_valid, m_instr, m_pc4, m_valid); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_zero_wait();
      test_load_use_stall();
      test_wait_states();
      test_branch_outstanding();
      test_branch_accept_stall();
      test_pc_wrap();
      test_reset_mid_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
